// File: rtl/traffic_phase_arbiter.sv
// Demand-actuated green-phase scheduler for the M1/M2/MT/S intersection.
// Latched vehicle requests are served round-robin; emergency input preempts.
//
// state  | meaning
// IDLE   | all red, waiting for a request or emergency
// GREEN  | approach cur is green, timers decide when to yield
// YELLOW | approach cur is yellow, fixed duration
// ALLRED | clearance interval, then next selection
module traffic_phase_arbiter #(
    parameter int TICK_DIV  = 100_000_000,
    parameter int MIN_GREEN = 3,
    parameter int MAX_GREEN = 7,
    parameter int YELLOW_T  = 2,
    parameter int ALLRED_T  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       emg_valid,
    input  logic [1:0] emg_id,
    output logic [2:0] light_M1,
    output logic [2:0] light_M2,
    output logic [2:0] light_MT,
    output logic [2:0] light_S,
    output logic [3:0] grant,
    output logic [3:0] remain,
    output logic       emg_ack
);

    localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, GREEN, YELLOW, ALLRED} state_t;

    state_t           state_q, state_d;
    logic [1:0]       cur_q, cur_d;
    logic [1:0]       rr_ptr_q, rr_ptr_d;
    logic [3:0]       pending_q, pending_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       sec_q, sec_d;
    logic [3:0][2:0]  lights_q, lights_d;
    logic [3:0]       grant_q, grant_d;
    logic [3:0]       remain_q, remain_d;
    logic             emg_ack_q, emg_ack_d;

    logic       tick;
    logic       others;
    logic       sel_valid;
    logic [1:0] sel;
    logic [1:0] scan_idx;
    int         sec_next;

    function automatic logic [3:0] sat9(input int v);
        if (v <= 0) return 4'd0;
        if (v >= 9) return 4'd9;
        return 4'(v);
    endfunction

    // Scan downward so the lowest offset from rr_ptr is the one left standing.
    always_comb begin
        sel       = rr_ptr_q;
        sel_valid = 1'b0;
        scan_idx  = '0;
        if (emg_valid) begin
            sel       = emg_id;
            sel_valid = 1'b1;
        end else begin
            for (int k = 3; k >= 0; k--) begin
                scan_idx = rr_ptr_q + 2'(k);
                if (pending_q[scan_idx]) begin
                    sel       = scan_idx;
                    sel_valid = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        rr_ptr_d  = rr_ptr_q;
        pending_d = pending_q | req;
        tick      = (div_q == DIV_LAST);
        sec_next  = int'(sec_q) + 1;
        others    = (|(pending_q & ~(4'b0001 << cur_q))) || (emg_valid && (emg_id != cur_q));

        case (state_q)
            IDLE: begin
                if (sel_valid) begin
                    state_d  = GREEN;
                    cur_d    = sel;
                    rr_ptr_d = sel + 2'd1;
                end
            end
            GREEN: begin
                if (emg_valid && (emg_id != cur_q)) begin
                    state_d = YELLOW;
                end else if (emg_valid) begin
                    state_d = GREEN;
                end else if (tick && others &&
                             (((sec_next >= MIN_GREEN) && !req[cur_q]) || (sec_next >= MAX_GREEN))) begin
                    state_d = YELLOW;
                end
            end
            YELLOW: begin
                if (tick && (sec_next >= YELLOW_T)) state_d = ALLRED;
            end
            ALLRED: begin
                if (tick && (sec_next >= ALLRED_T)) begin
                    if (sel_valid) begin
                        state_d  = GREEN;
                        cur_d    = sel;
                        rr_ptr_d = sel + 2'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if ((state_d == GREEN) && (state_q != GREEN)) pending_d[cur_d] = req[cur_d];

        if (state_d != state_q) begin
            div_d = '0;
            sec_d = '0;
        end else if (tick) begin
            div_d = '0;
            sec_d = (sec_q == 4'd15) ? 4'd15 : sec_q + 4'd1;
        end else begin
            div_d = div_q + DIV_W'(1);
            sec_d = sec_q;
        end

        lights_d = {4{3'b100}};
        grant_d  = '0;
        if ((state_d == GREEN) || (state_d == YELLOW)) begin
            grant_d         = 4'b0001 << cur_d;
            lights_d[cur_d] = (state_d == GREEN) ? 3'b001 : 3'b010;
        end

        case (state_d)
            GREEN:   remain_d = sat9(MAX_GREEN - int'(sec_d));
            YELLOW:  remain_d = sat9(YELLOW_T - int'(sec_d));
            ALLRED:  remain_d = sat9(ALLRED_T - int'(sec_d));
            default: remain_d = 4'd0;
        endcase

        emg_ack_d = (state_d == GREEN) && emg_valid && (emg_id == cur_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cur_q     <= '0;
            rr_ptr_q  <= '0;
            pending_q <= '0;
            div_q     <= '0;
            sec_q     <= '0;
            lights_q  <= {4{3'b100}};
            grant_q   <= '0;
            remain_q  <= '0;
            emg_ack_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            rr_ptr_q  <= rr_ptr_d;
            pending_q <= pending_d;
            div_q     <= div_d;
            sec_q     <= sec_d;
            lights_q  <= lights_d;
            grant_q   <= grant_d;
            remain_q  <= remain_d;
            emg_ack_q <= emg_ack_d;
        end
    end

    assign light_M1 = lights_q[0];
    assign light_M2 = lights_q[1];
    assign light_MT = lights_q[2];
    assign light_S  = lights_q[3];
    assign grant    = grant_q;
    assign remain   = remain_q;
    assign emg_ack  = emg_ack_q;

endmodule

// File: tb/tb_traffic_phase_arbiter.sv
// Bench for traffic_phase_arbiter: vector table of {inputs, hold cycles, expected outputs}
// plus a hand-timed asynchronous reset in the middle of a green phase.
module tb_traffic_phase_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = '0;
    logic       emg_valid = 1'b0;
    logic [1:0] emg_id = '0;
    logic [2:0] light_M1, light_M2, light_MT, light_S;
    logic [3:0] grant, remain;
    logic       emg_ack;

    traffic_phase_arbiter #(
        .TICK_DIV (4),
        .MIN_GREEN(3),
        .MAX_GREEN(7),
        .YELLOW_T (2),
        .ALLRED_T (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .emg_valid(emg_valid),
        .emg_id   (emg_id),
        .light_M1 (light_M1),
        .light_M2 (light_M2),
        .light_MT (light_MT),
        .light_S  (light_S),
        .grant    (grant),
        .remain   (remain),
        .emg_ack  (emg_ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       rst_v;
        logic [3:0] req;
        logic       ev;
        logic [1:0] eid;
        int         n;
        logic [3:0] g;
        logic       yel;
        logic [3:0] rem;
        logic       ack;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   split_at = 0;

    task automatic add(input string nm, input logic r, input logic [3:0] rq, input logic ev,
                       input logic [1:0] id, input int n, input logic [3:0] g, input logic y,
                       input logic [3:0] rem, input logic ack);
        vec_t v;
        v.name = nm; v.rst_v = r; v.req = rq; v.ev = ev; v.eid = id; v.n = n;
        v.g = g; v.yel = y; v.rem = rem; v.ack = ack;
        vecs.push_back(v);
    endtask

    function automatic logic [11:0] lamps(input logic [3:0] g, input logic y);
        logic [11:0] l;
        for (int i = 0; i < 4; i++) l[i*3 +: 3] = g[i] ? (y ? 3'b010 : 3'b001) : 3'b100;
        return l;
    endfunction

    task automatic chk(input string nm, input string what, input logic [11:0] act, input logic [11:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s %s: got %0h expected %0h at %0t", nm, what, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input vec_t e);
        chk(e.name, "lights", {light_S, light_MT, light_M2, light_M1}, lamps(e.g, e.yel));
        chk(e.name, "grant", {8'd0, grant}, {8'd0, e.g});
        chk(e.name, "remain", {8'd0, remain}, {8'd0, e.rem});
        chk(e.name, "emg_ack", {11'd0, emg_ack}, {11'd0, e.ack});
    endtask

    // Called at a falling edge; leaves the bench at a falling edge.
    task automatic apply(input int idx);
        vec_t v;
        vec_t e;
        v = vecs[idx];
        rst = v.rst_v; req = v.req; emg_valid = v.ev; emg_id = v.eid;
        exp_q.push_back(v);
        repeat (v.n) @(posedge clk);
        @(negedge clk);
        e = exp_q.pop_front();
        check_outputs(e);
    endtask

    initial begin
        vec_t rv;
        rv.name = "reset_state"; rv.g = '0; rv.yel = 1'b0; rv.rem = '0; rv.ack = 1'b0;

        //   name            rst req    ev id  n    grant   y rem ack
        add("idle_rest",      1, 4'h0, 0, 0, 3,   4'b0000, 0, 0, 0);
        add("m1_req",         1, 4'h1, 0, 0, 1,   4'b0000, 0, 0, 0);
        add("m1_green",       1, 4'h0, 0, 0, 1,   4'b0001, 0, 7, 0);
        add("m1_mid",         1, 4'h0, 0, 0, 5,   4'b0001, 0, 6, 0);
        split_at = vecs.size();
        add("idle_after_rst", 1, 4'h0, 0, 0, 8,   4'b0000, 0, 0, 0);
        add("mt_pulse",       1, 4'h4, 0, 0, 1,   4'b0000, 0, 0, 0);
        add("mt_green",       1, 4'h0, 0, 0, 1,   4'b0100, 0, 7, 0);
        add("mt_1s",          1, 4'h0, 0, 0, 4,   4'b0100, 0, 6, 0);
        add("mt_rest_100t",   1, 4'h0, 0, 0, 396, 4'b0100, 0, 0, 0);
        add("rst_a",          0, 4'h0, 0, 0, 1,   4'b0000, 0, 0, 0);
        add("rr_req_m1_s",    1, 4'h9, 0, 0, 1,   4'b0000, 0, 0, 0);
        add("rr_m1_green",    1, 4'h0, 0, 0, 1,   4'b0001, 0, 7, 0);
        add("rr_m1_end_grn",  1, 4'h0, 0, 0, 11,  4'b0001, 0, 5, 0);
        add("rr_m1_yellow",   1, 4'h0, 0, 0, 1,   4'b0001, 1, 2, 0);
        add("rr_m1_yel_end",  1, 4'h0, 0, 0, 7,   4'b0001, 1, 1, 0);
        add("rr_allred",      1, 4'h0, 0, 0, 1,   4'b0000, 0, 1, 0);
        add("rr_allred_end",  1, 4'h0, 0, 0, 3,   4'b0000, 0, 1, 0);
        add("rr_s_green",     1, 4'h0, 0, 0, 1,   4'b1000, 0, 7, 0);
        add("rst_b",          0, 4'h0, 0, 0, 1,   4'b0000, 0, 0, 0);
        add("mx_req_m1",      1, 4'h1, 0, 0, 1,   4'b0000, 0, 0, 0);
        add("mx_m1_green",    1, 4'h3, 0, 0, 1,   4'b0001, 0, 7, 0);
        add("mx_hold_27",     1, 4'h1, 0, 0, 27,  4'b0001, 0, 1, 0);
        add("mx_yellow_28",   1, 4'h1, 0, 0, 1,   4'b0001, 1, 2, 0);
        add("mx_m2_green",    1, 4'h0, 0, 0, 12,  4'b0010, 0, 7, 0);
        add("em_m1_sec1",     1, 4'h0, 0, 0, 28,  4'b0001, 0, 6, 0);
        add("em_preempt",     1, 4'h0, 1, 3, 1,   4'b0001, 1, 2, 0);
        add("em_s_green",     1, 4'h0, 1, 3, 12,  4'b1000, 0, 7, 1);
        add("em_req_m1",      1, 4'h1, 1, 3, 1,   4'b1000, 0, 7, 1);
        add("em_hold_40t",    1, 4'h0, 1, 3, 160, 4'b1000, 0, 0, 1);
        add("em_drop_ack",    1, 4'h0, 0, 3, 1,   4'b1000, 0, 0, 0);
        add("em_pre_tick",    1, 4'h0, 0, 3, 1,   4'b1000, 0, 0, 0);
        add("em_yield_tick",  1, 4'h0, 0, 3, 1,   4'b1000, 1, 2, 0);
        add("rst_c",          0, 4'h0, 0, 0, 1,   4'b0000, 0, 0, 0);
        add("eo_mt_pulse",    1, 4'h4, 0, 0, 1,   4'b0000, 0, 0, 0);
        add("eo_mt_green",    1, 4'h0, 0, 0, 1,   4'b0100, 0, 7, 0);
        add("eo_ack",         1, 4'h2, 1, 2, 1,   4'b0100, 0, 7, 1);
        add("eo_past_max",    1, 4'h0, 1, 2, 40,  4'b0100, 0, 0, 1);
        add("eo_drop",        1, 4'h0, 0, 2, 1,   4'b0100, 0, 0, 0);
        add("eo_pre_tick",    1, 4'h0, 0, 2, 1,   4'b0100, 0, 0, 0);
        add("eo_yield",       1, 4'h0, 0, 2, 1,   4'b0100, 1, 2, 0);

        #2 rst = 1'b0;
        #1 check_outputs(rv);
        @(negedge clk);

        for (int i = 0; i < split_at; i++) apply(i);

        // Reset lands mid-cycle with M1 green; outputs must clear before any edge.
        #2 rst = 1'b0;
        #1;
        rv.name = "async_rst_mid_green";
        check_outputs(rv);
        @(negedge clk);

        for (int i = split_at; i < vecs.size(); i++) apply(i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/traffic_phase_arbiter.md
Name: traffic_phase_arbiter

Overview:
Demand-driven green-phase scheduler for the four-approach intersection (M1, M2, MT, S). Vehicle-detect requests are latched and served round-robin. Each grant runs green, then yellow, then all-red clearance. An emergency input preempts the sequence. Drives the 3-bit lamp outputs and a seconds-remaining nibble for the existing 7-segment driver, and replaces the fixed-cycle sequencer on demand-actuated builds.

Parameters:
TICK_DIV, 100_000_000, clk cycles per one-second tick (sim uses 4)
MIN_GREEN, 3, minimum green seconds before yielding to another approach
MAX_GREEN, 7, green seconds after which a held own-request no longer extends
YELLOW_T, 2, yellow seconds
ALLRED_T, 1, all-red clearance seconds

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-low
req  in  4  vehicle-detect level/pulse; bit0 M1, bit1 M2, bit2 MT, bit3 S
emg_valid  in  1  emergency preemption request (level)
emg_id  in  2  approach index requested by emergency
light_M1  out  3  lamp {R,Y,G}: 100 red, 010 yellow, 001 green
light_M2  out  3  same encoding
light_MT  out  3  same encoding
light_S  out  3  same encoding
grant  out  4  one-hot approach currently green or yellow, 0 otherwise
remain  out  4  seconds left in current timed phase, saturated at 9
emg_ack  out  1  emergency approach is green

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset (rst=0) forces, immediately: state IDLE, all lights 100, grant 0, remain 0, emg_ack 0, pending 0, rr_ptr 0, cur 0, divider 0, sec_cnt 0.
- pending[i] is set on any clk where req[i]=1. It clears on the clk the approach enters GREEN; set wins if req[i] is still high that cycle.
- Divider counts 0..TICK_DIV-1, with tick on TICK_DIV-1. Divider and sec_cnt reset to 0 on every state change, so phases are whole seconds. sec_cnt increments on tick and saturates at 15.
- Selection: when emg_valid=1, choose emg_id. Otherwise choose the first set pending bit scanning from rr_ptr upward, modulo 4.
- IDLE: all red. If any pending or emg_valid, go to GREEN on the selected approach on the next clk. cur = selected; rr_ptr = cur+1.
- GREEN(cur): cur lamp 001, others 100. Let others = pending with bit cur masked out, OR emg_valid with emg_id != cur. Move to YELLOW on tick when:
  - sec_cnt+1 >= MIN_GREEN, others != 0, and req[cur]=0; or
  - sec_cnt+1 >= MAX_GREEN and others != 0.
- With others = 0, GREEN rests indefinitely.
- Preemption: emg_valid=1 with emg_id != cur forces YELLOW on the next clk, without waiting for a tick or MIN_GREEN.
- emg_valid=1 with emg_id == cur holds GREEN regardless of the timers, and emg_ack=1.
- YELLOW(cur): cur lamp 010. After YELLOW_T ticks go to ALLRED. Not interruptible.
- ALLRED: all lamps 100, grant 0. After ALLRED_T ticks, run selection (emg_id is sampled here). Go to GREEN if there is a candidate, else IDLE.
- At most one approach non-red at any time. grant[cur]=1 only in GREEN and YELLOW.
- remain:
  - GREEN: MAX_GREEN - sec_cnt, floored at 0.
  - YELLOW: YELLOW_T - sec_cnt.
  - ALLRED: ALLRED_T - sec_cnt.
  - IDLE: 0.
  - Saturate at 9 in all states.
- emg_ack = (state==GREEN) and emg_valid and (emg_id==cur). It drops on the clk after emg_valid falls.
- emg_valid dropping during YELLOW/ALLRED: the sequence completes normally. Selection falls back to round-robin.
- All outputs are registered.

Test Plan:
1. Reset during GREEN on M1 (pull rst low mid-phase) -> all lights 100, grant 0, remain 0 before the next clk edge. Release rst -> stays IDLE with no requests.
2. TICK_DIV=4. Single 1-clk pulse req=0100 from IDLE -> next clk light_MT=001, grant=0100, remain=7. No further requests -> MT green persists for 100 ticks.
3. req=1001 pulsed together from IDLE with rr_ptr=0 -> M1 green 3 s (12 clks), yellow 8 clks, all-red 4 clks, then S green, grant=1000.
4. M1 green with req[0] held high and req[1] pending -> M1 yellow exactly at 7 s (28 clks). Then M2 green.
5. M1 green at sec_cnt=1, raise emg_valid with emg_id=3 -> M1 yellow next clk, all-red, then S green with emg_ack=1. S holds green while emg_valid=1 for 40 ticks. Drop emg_valid with pending[0] set -> emg_ack 0 next clk, S yields on the next tick since S has already met MIN_GREEN.
6. emg_valid=1, emg_id=2 while MT already green -> no yellow, emg_ack=1 next clk, green holds past MAX_GREEN despite req[1] pending.
